// File: rtl/branch_predict_unit_if.sv
// Fetch/execute-facing signal bundle for branch_predict_unit.
// master = pipeline side (drives PCs and resolved outcomes), slave = predictor.
interface branch_predict_unit_if;
  logic        if_pc_dummy_unused;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [1:0]  ex_kind;
  logic        ex_call;
  logic        ex_ret;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_kind, ex_call, ex_ret, ex_taken,
           ex_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_kind, ex_call, ex_ret, ex_taken,
           ex_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit direction counters, perf counters, and an
// optional return-address stack enabled by defining BP_RAS_EN.
module branch_predict_unit #(
  parameter int ENTRIES   = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  res_n,
  branch_predict_unit_if.slave  bus,
  input  logic                  stat_clr,
  output logic [31:0]           br_cnt,
  output logic [31:0]           mis_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_r [ENTRIES];
  logic [1:0]       cnt_r   [ENTRIES];
  logic [TAG_W-1:0] tag_r   [ENTRIES];
  logic [31:0]      tgt_r   [ENTRIES];
  logic [1:0]       kind_r  [ENTRIES];

  logic [IDX_W-1:0] l_idx_s, u_idx_s;
  logic [TAG_W-1:0] l_tag_s, u_tag_s;
  logic             l_hit_s, u_hit_s, update_s, write_s;
  logic [1:0]       cnt_next_s;
  logic [31:0]      br_cnt_r, mis_cnt_r;

  function automatic logic [1:0] next_cnt(input logic [1:0] c, input logic taken,
                                          input logic jump);
    logic [1:0] n;
    if (jump) begin
      n = 2'b11;
    end else if (taken) begin
      n = (c == 2'b11) ? 2'b11 : c + 2'd1;
    end else begin
      n = (c == 2'b00) ? 2'b00 : c - 2'd1;
    end
    return n;
  endfunction

  assign l_idx_s    = bus.if_pc[IDX_W+1:2];
  assign l_tag_s    = bus.if_pc[31:IDX_W+2];
  assign u_idx_s    = bus.ex_pc[IDX_W+1:2];
  assign u_tag_s    = bus.ex_pc[31:IDX_W+2];
  assign l_hit_s    = valid_r[l_idx_s] && (tag_r[l_idx_s] == l_tag_s);
  assign u_hit_s    = valid_r[u_idx_s] && (tag_r[u_idx_s] == u_tag_s);
  // res_n gating keeps mispredict low while the core is held in reset
  assign update_s   = res_n && bus.ex_valid && (bus.ex_kind != 2'b11);
  assign write_s    = update_s && (u_hit_s || bus.ex_taken);
  assign cnt_next_s = u_hit_s ? next_cnt(cnt_r[u_idx_s], bus.ex_taken, bus.ex_kind != 2'b00)
                              : 2'b10;

  assign bus.mispredict  = update_s && ((bus.ex_taken != bus.ex_pred_taken) ||
                           (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
  assign bus.redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
  assign br_cnt  = br_cnt_r;
  assign mis_cnt = mis_cnt_r;

`ifdef BP_RAS_EN
  localparam int RAS_PW = $clog2(RAS_DEPTH);
  logic [31:0]     ras_mem_r [RAS_DEPTH];
  logic [RAS_PW:0] ras_cnt_r;
  logic [RAS_PW-1:0] ras_ptr_r;
  logic            ret_r [ENTRIES];
  logic            pop_s, push_s;
  logic [RAS_PW-1:0] ptr_pop_s;
  logic [RAS_PW:0] cnt_pop_s;

  assign pop_s     = update_s && bus.ex_ret && (ras_cnt_r != '0);
  assign push_s    = update_s && bus.ex_call;
  assign ptr_pop_s = pop_s ? ras_ptr_r - 1'b1 : ras_ptr_r;
  assign cnt_pop_s = pop_s ? ras_cnt_r - 1'b1 : ras_cnt_r;

  // Pop-then-push ordering lets a same-cycle call+ret overwrite the top entry
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ras_cnt_r <= '0;
      ras_ptr_r <= '0;
    end else if (push_s) begin
      ras_ptr_r <= ptr_pop_s + 1'b1;
      ras_cnt_r <= (cnt_pop_s == RAS_DEPTH[RAS_PW:0]) ? cnt_pop_s : cnt_pop_s + 1'b1;
    end else begin
      ras_ptr_r <= ptr_pop_s;
      ras_cnt_r <= cnt_pop_s;
    end
  end

  // Stack payload and per-entry ret flag carry no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      ras_mem_r[ptr_pop_s + 1'b1] <= bus.ex_pc + 32'd4;
    end
    if (write_s) begin
      ret_r[u_idx_s] <= bus.ex_ret;
    end
  end
`else
  logic unused_ras_s;
  assign unused_ras_s = bus.ex_call ^ bus.ex_ret ^ (RAS_DEPTH == 0);
`endif

  // Combinational lookup from registered table state
  always_comb begin
    bus.pred_taken  = 1'b0;
    bus.pred_target = bus.if_pc + 32'd4;
    if (l_hit_s && ((kind_r[l_idx_s] != 2'b00) || cnt_r[l_idx_s][1])) begin
      bus.pred_taken  = 1'b1;
      bus.pred_target = tgt_r[l_idx_s];
`ifdef BP_RAS_EN
      if ((kind_r[l_idx_s] == 2'b10) && ret_r[l_idx_s] && (ras_cnt_r != '0)) begin
        bus.pred_target = ras_mem_r[ras_ptr_r];
      end else begin
        bus.pred_target = tgt_r[l_idx_s];
      end
`endif
    end else begin
      bus.pred_taken  = 1'b0;
    end
  end

  // Valid bits and direction counters: cleared by reset
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i] <= 1'b0;
        cnt_r[i]   <= 2'b01;
      end
    end else if (write_s) begin
      valid_r[u_idx_s] <= 1'b1;
      cnt_r[u_idx_s]   <= cnt_next_s;
    end
  end

  // Entry payload (tag/target/kind) needs no reset behind the valid bit
  always_ff @(posedge clk) begin
    if (write_s) begin
      tag_r[u_idx_s]  <= u_tag_s;
      tgt_r[u_idx_s]  <= bus.ex_target;
      kind_r[u_idx_s] <= bus.ex_kind;
    end
  end

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      br_cnt_r  <= 32'd0;
      mis_cnt_r <= 32'd0;
    end else if (stat_clr) begin
      br_cnt_r  <= 32'd0;
      mis_cnt_r <= 32'd0;
    end else begin
      if (update_s && (br_cnt_r != 32'hFFFF_FFFF)) begin
        br_cnt_r <= br_cnt_r + 32'd1;
      end
      if (bus.mispredict && (mis_cnt_r != 32'hFFFF_FFFF)) begin
        mis_cnt_r <= mis_cnt_r + 32'd1;
      end
    end
  end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the combinational branch decision logic. It adds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, an optional return-address stack, and branch/mispredict performance counters. It sits between fetch, which gets the next-PC prediction, and execute, which supplies resolved outcomes and receives the redirect PC on a mispredict.

## Interface
Parameters:
- ENTRIES, 16: BTB/counter entries; power of two, ≥2. IDX_W = log2(ENTRIES).
- RAS_DEPTH, 4: return-stack entries; power of two; used only with BP_RAS_EN.

Ports:
- clk  in  1  clock, rising edge.
- res_n  in  1  reset, asynchronous, active-low.
- if_pc  in  32  fetch PC being looked up.
- pred_taken  out  1  prediction: redirect fetch to pred_target.
- pred_target  out  32  predicted next PC.
- ex_valid  in  1  resolved control instruction this cycle.
- ex_pc  in  32  PC of resolved instruction.
- ex_kind  in  2  00 cond branch, 01 JAL, 10 JALR, 11 none.
- ex_call  in  1  JAL/JALR with rd=x1/x5.
- ex_ret  in  1  JALR with rs1=x1/x5, rd≠x1/x5.
- ex_taken  in  1  actual direction (1 for jumps).
- ex_target  in  32  actual target, bit0 already cleared.
- ex_pred_taken  in  1  prediction carried with instruction.
- ex_pred_target  in  32  predicted target carried with instruction.
- mispredict  out  1  flush and redirect fetch this cycle.
- redirect_pc  out  32  correct next PC when mispredict=1.
- stat_clr  in  1  synchronous clear of performance counters.
- br_cnt  out  32  resolved control instructions.
- mis_cnt  out  32  mispredicts.

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- Each entry stores valid, tag, target[31:0], kind[1:0], cnt[1:0].
- Lookup is combinational from registered state:
  - hit = valid && tag match.
  - pred_taken = hit && (kind≠00 || cnt[1]).
  - pred_target = pred_taken ? entry target : if_pc+4. All adds are 32-bit, wrapping.
- An update occurs when ex_valid && ex_kind≠11.
  - Hit: target and kind are rewritten. cnt increments if taken, decrements if not, saturating at 11/00. Jumps force cnt=11.
  - Miss and taken: the entry is allocated (overwriting any occupant) with cnt=10.
  - Miss and not taken: no allocation.
- mispredict = update && (ex_taken≠ex_pred_taken || (ex_taken && ex_target≠ex_pred_target)). This is combinational.
- redirect_pc = ex_taken ? ex_target : ex_pc+4.
- Performance counters:
  - br_cnt increments on every update; mis_cnt increments on every mispredict.
  - Both saturate at 32'hFFFFFFFF.
  - stat_clr takes priority over increment in the same cycle.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update state; there is no bypass.
- ex_kind=11 with ex_valid=1: no update, no mispredict, no count.

## Timing
- Prediction has zero-cycle latency: combinational from if_pc.
- mispredict and redirect_pc are combinational in the resolve cycle.
- Table, RAS and counter writes take effect on the next rising clk edge. A lookup of the same PC one cycle later sees the new entry.
- Asynchronous reset (res_n=0) clears:
  - all valid bits to 0 and all cnt to 01;
  - RAS count to 0;
  - br_cnt and mis_cnt to 0.
- While in reset: pred_taken=0, pred_target=if_pc+4, mispredict=0. Asserting reset mid-operation discards all state immediately.
- Deassertion is synchronised externally; the first edge after release may update state.

## Configuration
- BP_RAS_EN defined: a RAS_DEPTH×32 return stack is present, with a circular pointer and a count.
  - Resolved ex_call pushes ex_pc+4. On overflow the oldest entry is overwritten and the count stays at RAS_DEPTH.
  - Resolved ex_ret pops. A pop when empty is ignored.
  - call && ret in the same cycle: pop then push, which replaces the top.
  - A BTB hit of kind JALR whose entry was last written by an ex_ret predicts the RAS top when the count is >0. A per-entry ret flag is stored for this.
- BP_RAS_EN undefined: no stack, no ret flag. ex_call and ex_ret are ignored. JALR predicts the stored BTB target.

## Test plan
- Reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104; br_cnt=mis_cnt=0.
- Resolve a BEQ at 0x100 as taken to 0x180, predicted not-taken → mispredict=1, redirect_pc=0x180. Next cycle a lookup of 0x100 gives pred_taken=1, pred_target=0x180.
- Resolve the same branch not-taken three times → cnt 10→01→00→00, pred_taken=0. The last of these resolutions (predicted not-taken) gives mispredict=0.
- Alias: with ENTRIES=16, PCs 0x100 and 0x140 share an index. Taken 0x140 evicts 0x100 → lookup 0x100 misses, pred_target=0x104.
- Counters: stat_clr=1 together with a mispredict → both counters 0 next cycle. Force br_cnt to 0xFFFFFFFF and resolve again → it stays at 0xFFFFFFFF.
- BP_RAS_EN: call at 0x200 (JAL) then JALR ret at 0x300, pushed twice beyond RAS_DEPTH → ret lookup predicts the latest 0x204-style return address. Pop on empty → falls back to the BTB target.
